card_dealer: RTL
================

CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have parameter: DEFAULT_SEED, 32'h2545F491, xorshift32 state loaded on reset.
REQ-002 SHALL have port: clock  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: seed  input  32  new generator state.
REQ-005 SHALL have port: seed_load  input  1  load seed (honoured in IDLE only).
REQ-006 SHALL have port: shuffle  input  1  return all 52 cards to deck (honoured in IDLE only).
REQ-007 SHALL have port: deal_req  input  1  request one card (honoured in IDLE only).
REQ-008 SHALL have port: card  output  6  dealt card index, 1..52, held until next card_valid.
REQ-009 SHALL have port: card_valid  output  1  one-cycle pulse, card is new.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port: dealt_count  output  6  cards dealt since reset/shuffle, 0..52.
REQ-012 SHALL have port: deck_empty  output  1  high when dealt_count == 52.

Function
REQ-013 SHALL implement FSM IDLE -> STEP -> REDUCE -> CHECK -> IDLE (or CHECK -> STEP on collision).
REQ-014 STEP SHALL advance 32-bit state once: s^=s<<13; s^=s>>17; s^=s<<5 (shifts zero-fill, result truncated to 32 bits).
REQ-015 REDUCE SHALL compute new state mod 52 by restoring shift-subtract, one bit per cycle, MSB first, exactly 32 cycles.
REQ-016 CHECK SHALL test 52-bit dealt mask at remainder r: if clear, set bit, card<=r+1, card_valid=1 next cycle, dealt_count+1, go IDLE; if set, go STEP (redraw).
REQ-017 Collision-free latency SHALL be 34 cycles: card_valid high in 35th cycle after the accepting edge; each redraw adds 34 cycles.
REQ-018 deal_req SHALL be ignored (no state change, busy stays low) while deck_empty.
REQ-019 seed_load, shuffle, deal_req SHALL be ignored while busy; no queuing.
REQ-020 Simultaneous in IDLE: seed_load and shuffle both apply; deal_req is dropped if seed_load or shuffle is high in the same cycle.
REQ-021 Seed value 0 SHALL be replaced by 32'h00000001 on load (xorshift fixed point avoided).
REQ-022 shuffle SHALL clear mask and dealt_count next cycle, leaving generator state unchanged.

Reset
REQ-023 reset SHALL, on the next edge and from any state: FSM=IDLE, state=DEFAULT_SEED (0 substituted as REQ-021), mask=0, dealt_count=0, card=0, card_valid=0, busy=0, deck_empty=0.
REQ-024 reset mid-REDUCE/CHECK SHALL abort the deal with no card_valid and no mask update.

Configuration
REQ-025 Macro CARD_DEALER_PROBE_EN defined: on collision CHECK SHALL advance r to (r+1) mod 52 (51 wraps to 0) and re-check next cycle without redraw; each probe adds 1 cycle.
REQ-026 Macro undefined: collision SHALL redraw via STEP per REQ-016; no probe logic synthesised.

Structure
REQ-027 Package card_dealer_pkg SHALL hold DECK_SIZE=52, shift constants 13/17/5, FSM state enum, DEFAULT_SEED default.
REQ-028 Sub-module dealer_mod52 SHALL implement the sequential reducer (start, 32-bit dividend, done, 6-bit remainder).

Verification
REQ-029 Reset, seed_load seed=1, deal_req -> card_valid 34 cycles later, card=22 (state 0x00042021, rem 21), dealt_count=1.
REQ-030 seed_load seed=0, deal_req -> identical result to seed=1 (card=22).
REQ-031 52 consecutive deals -> each of 1..52 exactly once, deck_empty high after 52nd; 53rd deal_req -> busy stays 0, no card_valid.
REQ-032 reset asserted 10 cycles into REDUCE -> next cycle busy=0, dealt_count=0, no card_valid ever for that request.
REQ-033 deal_req, seed_load, shuffle pulsed while busy -> ignored; card, state sequence match undisturbed model.
REQ-034 With CARD_DEALER_PROBE_EN, full 52-card deal from seed=1 -> completes within 52*(34+51) cycles, all cards unique.

Source files
------------

// File: rtl/card_dealer_pkg.sv
// card_dealer_pkg: shared constants, FSM state type and generator helpers
// for the card dealer (deck size, xorshift32 shift amounts, reset seed).
package card_dealer_pkg;

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned CARD_W    = 6;
  localparam int unsigned STATE_W   = 32;

  localparam int unsigned SH_A = 13;
  localparam int unsigned SH_B = 17;
  localparam int unsigned SH_C = 5;

  localparam logic [STATE_W-1:0] DEFAULT_SEED_VALUE = 32'h2545F491;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_REDUCE = 2'd2,
    ST_CHECK  = 2'd3
  } dealer_state_e;

  // One xorshift32 step; shifts zero-fill and truncate to 32 bits.
  function automatic logic [STATE_W-1:0] xorshift32_next(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] t;
    t = s ^ (s << SH_A);
    t = t ^ (t >> SH_B);
    t = t ^ (t << SH_C);
    return t;
  endfunction

  // Zero is a fixed point of xorshift, so it is never allowed as a state.
  function automatic logic [STATE_W-1:0] nonzero_seed(input logic [STATE_W-1:0] s);
    return (s == '0) ? STATE_W'(1) : s;
  endfunction

endpackage

// File: rtl/card_dealer_mod52.sv
// dealer_mod52: sequential restoring reducer, dividend mod 52, one dividend
// bit per cycle MSB first, exactly 32 cycles after start.
// Ports:
//   clock, reset     - rising-edge clock, synchronous active-high reset
//   start            - load dividend and begin (ignored state is overwritten)
//   dividend [31:0]  - value to reduce
//   done             - combinational: the final bit is consumed at this edge
//   remainder [5:0]  - result, valid from the cycle after done
module dealer_mod52
  import card_dealer_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [STATE_W-1:0] dividend,
  output logic               done,
  output logic [CARD_W-1:0]  remainder
);

  localparam int unsigned CNT_W = 6;

  logic [STATE_W-1:0] dvd;
  logic [CARD_W-1:0]  rem;
  logic [CNT_W-1:0]   cnt;
  logic [CARD_W:0]    trial_c;

  // Partial remainder is always < 52, so shifting in one bit stays < 104.
  assign trial_c   = {rem, dvd[STATE_W-1]};
  assign done      = (cnt == CNT_W'(1));
  assign remainder = rem;

  // Shift-subtract datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      dvd <= '0;
      rem <= '0;
      cnt <= '0;
    end else if (start) begin
      dvd <= dividend;
      rem <= '0;
      cnt <= CNT_W'(STATE_W);
    end else if (cnt != '0) begin
      if (trial_c >= (CARD_W+1)'(DECK_SIZE))
        rem <= CARD_W'(trial_c - (CARD_W+1)'(DECK_SIZE));
      else
        rem <= trial_c[CARD_W-1:0];
      dvd <= {dvd[STATE_W-2:0], 1'b0};
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/card_dealer.sv
// card_dealer: deals cards 1..52 without replacement using an xorshift32
// generator reduced mod 52 and a 52-bit dealt mask.
// Ports:
//   clock, reset       - rising-edge clock, synchronous active-high reset
//   seed, seed_load    - load generator state (IDLE only, 0 becomes 1)
//   shuffle            - return all cards to the deck (IDLE only)
//   deal_req           - request one card (IDLE only, not when deck empty)
//   card, card_valid   - dealt card (held) and its one-cycle strobe
//   busy               - FSM not in IDLE
//   dealt_count        - cards dealt since reset/shuffle
//   deck_empty         - all 52 cards dealt
// Build option: define CARD_DEALER_PROBE_EN to resolve collisions by linear
// probing (r+1 mod 52, one cycle each) instead of redrawing.
module card_dealer
  import card_dealer_pkg::*;
#(
  parameter logic [31:0] DEFAULT_SEED = DEFAULT_SEED_VALUE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [STATE_W-1:0] seed,
  input  logic               seed_load,
  input  logic               shuffle,
  input  logic               deal_req,
  output logic [CARD_W-1:0]  card,
  output logic               card_valid,
  output logic               busy,
  output logic [CARD_W-1:0]  dealt_count,
  output logic               deck_empty
);

  dealer_state_e        fsm;
  logic [STATE_W-1:0]   gen;
  logic [STATE_W-1:0]   gen_next_c;
  logic [DECK_SIZE-1:0] mask;
  logic                 red_start_c;
  logic                 red_done;
  logic [CARD_W-1:0]    red_rem;
  logic [CARD_W-1:0]    idx_c;

  assign gen_next_c  = xorshift32_next(gen);
  assign red_start_c = (fsm == ST_STEP);

  // Reducer is loaded with the freshly advanced state at the STEP edge.
  dealer_mod52 u_mod52 (
    .clock     (clock),
    .reset     (reset),
    .start     (red_start_c),
    .dividend  (gen_next_c),
    .done      (red_done),
    .remainder (red_rem)
  );

`ifdef CARD_DEALER_PROBE_EN
  logic [CARD_W-1:0] probe_r;
  logic              probing;
  // First CHECK uses the reducer result, later probes the advanced index.
  assign idx_c = probing ? probe_r : red_rem;
`else
  assign idx_c = red_rem;
`endif

  // Control FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm         <= ST_IDLE;
      gen         <= nonzero_seed(DEFAULT_SEED);
      mask        <= '0;
      dealt_count <= '0;
      card        <= '0;
      card_valid  <= 1'b0;
      busy        <= 1'b0;
      deck_empty  <= 1'b0;
`ifdef CARD_DEALER_PROBE_EN
      probe_r     <= '0;
      probing     <= 1'b0;
`endif
    end else begin
      card_valid <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (seed_load)
            gen <= nonzero_seed(seed);
          if (shuffle) begin
            mask        <= '0;
            dealt_count <= '0;
            deck_empty  <= 1'b0;
          end
          // A deal is dropped if any housekeeping happens in the same cycle.
          if (deal_req && !seed_load && !shuffle && !deck_empty) begin
            fsm  <= ST_STEP;
            busy <= 1'b1;
          end
        end
        ST_STEP: begin
          gen <= gen_next_c;
          fsm <= ST_REDUCE;
        end
        ST_REDUCE: begin
          if (red_done)
            fsm <= ST_CHECK;
        end
        ST_CHECK: begin
          if (!mask[idx_c]) begin
            mask[idx_c] <= 1'b1;
            card        <= idx_c + CARD_W'(1);
            card_valid  <= 1'b1;
            dealt_count <= dealt_count + CARD_W'(1);
            deck_empty  <= (dealt_count == CARD_W'(DECK_SIZE - 1));
            busy        <= 1'b0;
            fsm         <= ST_IDLE;
`ifdef CARD_DEALER_PROBE_EN
            probing     <= 1'b0;
`endif
          end else begin
`ifdef CARD_DEALER_PROBE_EN
            probe_r <= (idx_c == CARD_W'(DECK_SIZE - 1)) ? '0 : idx_c + CARD_W'(1);
            probing <= 1'b1;
`else
            fsm     <= ST_STEP;
`endif
          end
        end
        default: begin
          fsm  <= ST_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
